// File: rtl/bcd_display_scan.sv
// bcd_display_scan: drives a 4-digit multiplexed common-anode 7-segment display
// from four BCD/hex digits. A refresh prescaler advances a rotating digit index.
// The inputs are snapshotted at the start of each frame, so a digit change in the
// middle of a scan never tears a frame. All pin outputs are registered.
// Optional build macro: LEADING_ZERO_BLANK_EN turns off leading zeros on
// digits 3..1. Digit0 is never blanked.
module bcd_display_scan #(
  parameter int DIV = 25000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [15:0] DIGITS,
  input  logic [3:0]  DP_MASK,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        FRAME
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST_COUNT = PW'(DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [15:0]   snapshot;
  logic [3:0]    dp_snap;

  logic          tick;
  logic [1:0]    next_idx;
  logic          new_frame;
  logic [15:0]   sel_digits;
  logic [3:0]    sel_dp;
  logic [3:0]    sel_nibble;
  logic          sel_blank;
  logic [3:0]    next_an;
  logic [6:0]    next_seg;
  logic          next_dp;

  // Active-low glyph table, bit order {g,f,e,d,c,b,a}; A-F show as hex for error codes
  function automatic logic [6:0] glyph(input logic [3:0] value);
    logic [6:0] g;
    case (value)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // A digit is a leading zero when it and every more-significant digit are zero
  function automatic logic leading_zero(input logic [1:0] pos, input logic [15:0] d);
    logic z;
`ifdef LEADING_ZERO_BLANK_EN
    case (pos)
      2'd3:    z = (d[15:12] == 4'h0);
      2'd2:    z = (d[15:8] == 8'h00);
      2'd1:    z = (d[15:4] == 12'h000);
      default: z = 1'b0;
    endcase
`else
    z = 1'b0;
`endif
    return z;
  endfunction

  // Slot timing and the next digit to show. The frame's first slot uses the live inputs,
  // because the snapshot is loaded on that same edge.
  always_comb begin
    tick       = EN && (prescaler == LAST_COUNT);
    next_idx   = (idx == 2'd3) ? 2'd0 : idx + 2'd1;
    new_frame  = (next_idx == 2'd0);
    sel_digits = new_frame ? DIGITS : snapshot;
    sel_dp     = new_frame ? DP_MASK : dp_snap;
    sel_nibble = sel_digits[{next_idx, 2'b00} +: 4];
    sel_blank  = leading_zero(next_idx, sel_digits);
    next_an    = ~(4'b0001 << next_idx);
    next_seg   = sel_blank ? 7'h7F : glyph(sel_nibble);
    next_dp    = ~sel_dp[next_idx];
  end

  // Refresh prescaler: free-runs 0..DIV-1 while enabled, parked at 0 otherwise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      prescaler <= '0;
    end else if (!EN || tick) begin
      prescaler <= '0;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  // Digit index and frame snapshot. Index 3 is the park position, so the first tick lands on digit0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx      <= 2'd3;
      snapshot <= '0;
      dp_snap  <= '0;
    end else if (!EN) begin
      idx <= 2'd3;
    end else if (tick) begin
      idx <= next_idx;
      if (new_frame) begin
        snapshot <= DIGITS;
        dp_snap  <= DP_MASK;
      end
    end
  end

  // Registered pin drivers: anode, cathodes and frame marker all switch on the tick edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      AN    <= 4'b1111;
      SEG   <= 7'h7F;
      DP    <= 1'b1;
      FRAME <= 1'b0;
    end else if (!EN) begin
      AN    <= 4'b1111;
      SEG   <= 7'h7F;
      DP    <= 1'b1;
      FRAME <= 1'b0;
    end else if (tick) begin
      AN    <= next_an;
      SEG   <= next_seg;
      DP    <= next_dp;
      FRAME <= new_frame;
    end else begin
      FRAME <= 1'b0;
    end
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Reader side of the millisecond counter chain. Takes four BCD/hex digits from the counter stage and drives a 4-digit multiplexed common-anode 7-segment display. Uses a refresh prescaler, a rotating digit index and a frame-coherent snapshot of the inputs, so a count change mid-scan never tears a frame. Registered outputs go straight to board pins.

Parameters:
DIV, 25000, CLK cycles per digit slot (≥2); 100 MHz → 4 kHz slot, 1 kHz frame
PW, $clog2(DIV), prescaler width (derived, localparam)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
EN  in  1  scan enable; low = display dark, scan held at start
DIGITS  in  16  four 4-bit digits; [3:0]=digit0 (rightmost, LS), [15:12]=digit3
DP_MASK  in  4  decimal point per digit, 1=lit; bit i ↔ digit i
AN  out  4  anode select, active-low, bit i ↔ digit i
SEG  out  7  cathodes {g,f,e,d,c,b,a}, active-low
DP  out  1  decimal point cathode, active-low
FRAME  out  1  1-cycle pulse when digit0 slot begins (new snapshot taken)

Behaviour:
- Reset (async, RST=1): prescaler=0, idx=3, snapshot=0, dp_snap=0, AN=4'b1111, SEG=7'h7F, DP=1, FRAME=0.
- Reset is fully asynchronous. Asserting RST mid-frame blanks the display immediately (AN=1111). There is no partial-frame recovery.
- Prescaler: while EN=1, counts 0..DIV-1 and wraps. tick = EN && prescaler==DIV-1.
- On tick, idx <= (idx==3) ? 0 : idx+1. All outputs are registered from the new idx in the same edge. Latency is 1 cycle from the tick condition to the pin change.
- First tick after reset or after EN rises occurs DIV cycles after EN is sampled high. It selects digit0.
- Snapshot: on a tick where the new idx=0, DIGITS→snapshot and DP_MASK→dp_snap in the same edge. FRAME=1 for that one cycle only. Digits 1..3 of a frame always show this snapshot. Input changes mid-frame appear at the next frame.
- Drive: AN = ~(1<<idx). SEG = glyph(snapshot nibble idx). DP = ~dp_snap[idx].
- Glyphs (active-low hex, {g..a}): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E. Codes A–F are shown as hex, used as error indication.
- EN=0 (synchronous): prescaler<=0, idx<=3, AN<=1111, SEG<=7F, DP<=1, FRAME<=0. The snapshot is retained.
- AN and SEG change on the same edge, with no glitch cycle between them (all registered).

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: for digits 3, 2, 1 (never digit0), SEG=7F when that snapshot nibble is 0 and every more-significant snapshot nibble is 0. AN still rotates, and DP still follows dp_snap. Example: 0x0050 shows " 50"; 0x0000 shows "0".
- Undefined: all four digits always show their glyph, including leading zeros.

Test Plan:
1. DIV=4. RST pulse, hold EN=0 for 10 cycles → AN=1111, SEG=7F, DP=1, FRAME=0 throughout.
2. DIV=4, DIGITS=16'h1234, DP_MASK=4'b0100, EN=1 → at cycle 4 after EN: FRAME=1, AN=1110, SEG=19 ('4'). Then every 4 cycles: AN=1101/SEG=30, then AN=1011/SEG=24/DP=0, then AN=0111/SEG=79, then back to AN=1110 with FRAME=1.
3. Tearing: change DIGITS from 1234 to 5678 while digit1 is shown → digits 2 and 3 still show '2' and '1'. The next digit0 slot shows '8' with FRAME=1.
4. DIGITS=16'hABCD → glyphs 21, 46, 03, 08 on digits 0..3. With LEADING_ZERO_BLANK_EN, DIGITS=16'h0050 → digit3 and digit2 SEG=7F, digit1=12, digit0=40. DIGITS=0 → only digit0 shows 40.
5. Assert RST asynchronously mid-slot (between edges) → AN=1111 and SEG=7F immediately, without waiting for a clock edge. After release, the first digit0 appears DIV cycles later.
6. Drop EN during digit2 → next edge AN=1111. Re-raise EN → digit0 after DIV cycles, with FRAME=1 and a fresh snapshot.
